digit_entry_buffer: RTL
=======================

Name: digit_entry_buffer

Overview:
- Parametrised keypad digit accumulator for the calculator datapath; successor to the fixed 10-digit number store.
- Synchronous, single clock domain, with internal rising-edge detection on key strobes.
- Adds backspace, clear, digit-range rejection and a selectable positional/shift entry order.
- Overflow is dropped rather than overwritten, and completed numbers are committed through a valid/ready output handshake.

Parameters:
- DIGITS, 10: number of digit slots.
- DIGIT_W, 4: bits per digit.
- MAX_DIGIT, 9: largest accepted digit value; larger values are rejected.
- SHIFT_MODE, 0: entry order. 0 = positional (first digit in slot 0). 1 = calculator shift (newest digit in slot 0, older digits move up).
- CNT_W, derived as clog2(DIGITS+1): width of the count outputs; not overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- new_digit  in  1  digit key level; acted on at its rising edge
- digit  in  DIGIT_W  digit value, sampled at the new_digit edge
- backspace  in  1  delete-last key level; edge-acted
- clear  in  1  clear-entry key level; edge-acted
- save  in  1  commit key level; edge-acted
- num_actual  out  DIGITS*DIGIT_W  live buffer; slot i is at bits [i*DIGIT_W +: DIGIT_W]
- count  out  CNT_W  digits currently held
- full  out  1  high when count==DIGITS
- overflow  out  1  sticky: a digit was dropped because the buffer was full
- reject  out  1  one-cycle pulse: digit value > MAX_DIGIT, or save refused
- num_valid  out  1  committed number pending
- num_ready  in  1  consumer accepts the committed number
- num_out  out  DIGITS*DIGIT_W  committed digits
- num_count  out  CNT_W  digit count of the committed number

Behaviour:
- Reset: rst high asynchronously zeroes all slots, count, overflow, reject, num_valid, num_out, num_count and the edge-detect history registers.
- Event definition: an event fires when the input is sampled 1 at a clk edge and was 0 at the previous edge. A held key therefore produces exactly one event.
- Latency: the state update happens at that same edge, so outputs change one cycle after the input rises.
- Same-cycle priority: clear > save > backspace > new_digit. Only the highest-priority event is acted on; the others are discarded.
- new_digit, digit > MAX_DIGIT: no state change; reject pulses.
- new_digit, count==DIGITS: digit is dropped; overflow is set. The stored contents are never overwritten.
- new_digit, positional mode: slot[count] <= digit; count+1.
- new_digit, shift mode: slot[i] <= slot[i-1] for i>0; slot0 <= digit; count+1.
- backspace, count==0: no-op.
- backspace, positional mode: slot[count-1] <= 0; count-1.
- backspace, shift mode: slot[i] <= slot[i+1]; top slot <= 0; count-1.
- backspace does not clear overflow.
- clear: all slots, count and overflow go to 0. The pending num_out and num_valid are unaffected.
- Output FSM, two states:
  - IDLE (num_valid=0).
  - HOLD (num_valid=1); num_out and num_count are frozen while in HOLD.
- save in IDLE: num_out <= buffer; num_count <= count; buffer, count and overflow clear; go to HOLD. A save with count==0 is legal and commits zero with num_count=0.
- HOLD with num_ready=1 at an edge: transfer completes; go to IDLE. num_valid is low from the next cycle.
- save in HOLD with num_ready=0: refused; reject pulses; the buffer is retained.
- save in HOLD with num_ready=1 in the same cycle: the new capture replaces the old one; stay in HOLD; num_valid stays 1.
- Digit entry, backspace and clear continue in both FSM states (double-buffered).
- Reset mid-entry or mid-HOLD returns everything to the reset state immediately. No partial transfer is reported.

Optional Feature:
- Macro: DIGIT_ENTRY_SIGN_EN.
- When defined, adds:
  - input sign_toggle, edge-acted, priority below backspace;
  - output neg;
  - output num_neg.
- sign_toggle flips neg. save copies neg to num_neg and clears neg. clear zeroes neg. Reset zeroes neg and num_neg.
- When undefined: these ports and registers are absent and the number is unsigned.

Test Plan:
- Positional mode, after reset: keys 1,2,3 -> num_actual[11:0]=0x321, count=3. backspace -> slot2=0, count=2.
- SHIFT_MODE=1: keys 4,5,6 -> slot0=6, slot1=5, slot2=4. backspace -> slot0=5, slot1=4, count=2.
- Enter 10 digits, then 7 -> full=1, overflow=1, slot9 unchanged, count=10. clear -> all zero, overflow=0.
- digit=0xA with new_digit -> one-cycle reject, count unchanged. new_digit held 5 cycles -> one digit stored.
- Enter 8,9; save with num_ready=0 -> num_valid=1, num_out=0x98, num_count=2, count=0. Enter 1 and save again -> reject, buffer=1. Raise num_ready -> num_valid drops the next cycle.
- rst asserted mid-HOLD, asynchronously between clock edges -> num_valid=0 and count=0 without waiting for a clk edge. Also: new_digit and clear rising in the same cycle -> clear wins, count=0.

Source files
------------

// File: rtl/digit_entry_buffer.sv
// Keypad digit accumulator with edge-detected keys; state updates on the edge that samples a key rise.
// Commits via num_valid/num_ready (save refused while held unless taken); optional sign via DIGIT_ENTRY_SIGN_EN.
module digit_entry_buffer #(
  parameter int DIGITS     = 10,
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGIT  = 9,
  parameter int SHIFT_MODE = 0,
  localparam int CNT_W     = $clog2(DIGITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        new_digit,
  input  logic [DIGIT_W-1:0]          digit,
  input  logic                        backspace,
  input  logic                        clear,
  input  logic                        save,
  output logic [DIGITS*DIGIT_W-1:0]   num_actual,
  output logic [CNT_W-1:0]            count,
  output logic                        full,
  output logic                        overflow,
  output logic                        reject,
  output logic                        num_valid,
  input  logic                        num_ready,
  output logic [DIGITS*DIGIT_W-1:0]   num_out,
  output logic [CNT_W-1:0]            num_count
`ifdef DIGIT_ENTRY_SIGN_EN
  ,
  input  logic                        sign_toggle,
  output logic                        neg,
  output logic                        num_neg
`endif
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [DIGIT_W-1:0]   slot     [DIGITS];
  logic [DIGIT_W-1:0]   slot_nxt [DIGITS];
  logic [CNT_W-1:0]     count_nxt;
  logic                 overflow_nxt, reject_nxt;
  logic                 new_digit_q, backspace_q, clear_q, save_q;
  logic                 ev_digit, ev_bs, ev_clear, ev_save;
  logic                 act_clear, act_save, act_bs, act_digit, save_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_digit_q <= 1'b0;
      backspace_q <= 1'b0;
      clear_q     <= 1'b0;
      save_q      <= 1'b0;
    end else begin
      new_digit_q <= new_digit;
      backspace_q <= backspace;
      clear_q     <= clear;
      save_q      <= save;
    end
  end

  assign ev_digit = new_digit & ~new_digit_q;
  assign ev_bs    = backspace & ~backspace_q;
  assign ev_clear = clear & ~clear_q;
  assign ev_save  = save & ~save_q;

  assign act_clear = ev_clear;
  assign act_save  = ev_save & ~ev_clear;
  assign act_bs    = ev_bs & ~ev_clear & ~ev_save;

`ifdef DIGIT_ENTRY_SIGN_EN
  logic sign_q, ev_sign, act_sign, neg_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sign_q <= 1'b0;
    else     sign_q <= sign_toggle;
  end

  assign ev_sign   = sign_toggle & ~sign_q;
  assign act_sign  = ev_sign & ~ev_clear & ~ev_save & ~ev_bs;
  assign act_digit = ev_digit & ~ev_clear & ~ev_save & ~ev_bs & ~ev_sign;
`else
  assign act_digit = ev_digit & ~ev_clear & ~ev_save & ~ev_bs;
`endif

  // A save while holding only succeeds if the consumer takes the old number this same edge.
  assign save_ok = act_save & ((state == IDLE) | num_ready);
  assign full    = (count == CNT_W'(DIGITS));

  always_comb begin
    for (int i = 0; i < DIGITS; i++) slot_nxt[i] = slot[i];
    count_nxt    = count;
    overflow_nxt = overflow;
    reject_nxt   = 1'b0;
    if (act_clear || save_ok) begin
      for (int i = 0; i < DIGITS; i++) slot_nxt[i] = '0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end else if (act_save) begin
      reject_nxt = 1'b1;
    end else if (act_bs) begin
      if (count != '0) begin
        if (SHIFT_MODE != 0) begin
          for (int i = 0; i < DIGITS - 1; i++) slot_nxt[i] = slot[i+1];
          slot_nxt[DIGITS-1] = '0;
        end else begin
          for (int i = 0; i < DIGITS; i++)
            if (CNT_W'(i) == count - 1'b1) slot_nxt[i] = '0;
        end
        count_nxt = count - 1'b1;
      end
    end else if (act_digit) begin
      if (digit > DIGIT_W'(MAX_DIGIT)) begin
        reject_nxt = 1'b1;
      end else if (full) begin
        overflow_nxt = 1'b1;
      end else begin
        if (SHIFT_MODE != 0) begin
          for (int i = 1; i < DIGITS; i++) slot_nxt[i] = slot[i-1];
          slot_nxt[0] = digit;
        end else begin
          for (int i = 0; i < DIGITS; i++)
            if (CNT_W'(i) == count) slot_nxt[i] = digit;
        end
        count_nxt = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) slot[i] <= '0;
      count    <= '0;
      overflow <= 1'b0;
      reject   <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) slot[i] <= slot_nxt[i];
      count    <= count_nxt;
      overflow <= overflow_nxt;
      reject   <= reject_nxt;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_pack
    assign num_actual[g*DIGIT_W +: DIGIT_W] = slot[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (save_ok) state_nxt = HOLD;
      HOLD: if (num_ready && !save_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    num_valid = (state == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_out   <= '0;
      num_count <= '0;
    end else if (save_ok) begin
      num_out   <= num_actual;
      num_count <= count;
    end
  end

`ifdef DIGIT_ENTRY_SIGN_EN
  always_comb begin
    neg_nxt = neg;
    if (act_clear || save_ok) neg_nxt = 1'b0;
    else if (act_sign)        neg_nxt = ~neg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg     <= 1'b0;
      num_neg <= 1'b0;
    end else begin
      neg <= neg_nxt;
      if (save_ok) num_neg <= neg;
    end
  end
`endif

endmodule
